serial_csa_accumulator: RTL and testbench
=========================================

SERIAL_CSA_ACCUMULATOR -- requirements
Module: serial_csa_accumulator

Interface
REQ-001 Parameter N, default 4, operand width in bits.
REQ-002 Parameter M, default 8, result width in bits; M SHALL be greater than N.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand present on in_data.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 in_data  input  N  unsigned operand.
REQ-008 in_last  input  1  qualifies in_data as the final operand of the current group.
REQ-009 out_valid  output  1  out_sum holds a completed group result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  M  group sum modulo 2^M.
REQ-012 out_count  output  M  number of operands in the group, modulo 2^M.
REQ-013 out_ovf  output  1  true group sum exceeded 2^M-1; present only when ACC_OVF_EN is defined.

Function
REQ-014 The FSM SHALL have exactly three states: ACCUM, RESOLVE and OUT.
REQ-015 In ACCUM, in_ready=1 and out_valid=0; in RESOLVE and OUT, in_ready=0.
REQ-016 An input transfer SHALL occur only on a cycle where in_valid=1 and in_ready=1.
REQ-017 State is a carry-save pair, sum vector S[M-1:0] and carry vector C[M-1:0], both 0 at group start.
REQ-018 On each input transfer: S<=S^C^X and C<=maj(S,C,X)<<1, where X is in_data zero-extended to M bits; carry-propagate addition is forbidden in this path.
REQ-019 On each input transfer the operand counter SHALL increment by 1, wrapping modulo 2^M.
REQ-020 An input transfer with in_last=1 SHALL move the FSM to RESOLVE; with in_last=0 the FSM stays in ACCUM.
REQ-021 RESOLVE SHALL last exactly one cycle: result<=(S+C) mod 2^M, count latched, then the FSM moves to OUT.
REQ-022 In OUT, out_valid=1 and out_sum/out_count SHALL hold stable until out_ready=1.
REQ-023 On an out_valid&&out_ready cycle, S, C and the counter SHALL clear and the FSM returns to ACCUM; in_ready rises on the following cycle.
REQ-024 Latency: a last-operand transfer at cycle t SHALL give out_valid=1 at cycle t+2.
REQ-025 A single-operand group (in_last on the first transfer) SHALL return out_sum=operand and out_count=1.
REQ-026 out_valid SHALL NOT fall without a completed handshake.
REQ-027 in_valid while in_ready=0 SHALL be ignored and SHALL NOT alter state.
REQ-028 Throughput: one operand per cycle in ACCUM; groups are separated by at least 2 non-accepting cycles (RESOLVE plus OUT).

Reset
REQ-029 When rst is asserted, the FSM SHALL go to ACCUM immediately, with S=0, C=0, counter=0, result=0, out_valid=0, out_sum=0, out_count=0 and out_ovf=0.
REQ-030 in_ready SHALL be 1 once reset completes.
REQ-031 Reset asserted mid-group or in OUT SHALL discard the partial group or the pending result with no output transfer.

Configuration
REQ-032 Macro ACC_OVF_EN.
  - Defined: a sticky overflow bit sets when C[M-1] is shifted out as nonzero during a transfer, or when the RESOLVE add has carry-out.
  - out_ovf SHALL be valid alongside out_sum and SHALL clear with the group.
REQ-033 Without ACC_OVF_EN, no out_ovf port exists, no overflow logic is built, and out_sum wraps silently.

Verification
REQ-034 Operands 3,5,7,9 with last on 9, out_ready=1 -> out_sum=24, out_count=4, out_valid exactly 2 cycles after the last transfer.
REQ-035 Operand 15 with last on the first beat -> out_sum=15, out_count=1.
REQ-036 Group 1,2 then out_ready held 0 for 5 cycles -> out_sum=3 stable, in_ready=0 throughout; the next group 4,4 -> out_sum=8, so no residue from the prior group.
REQ-037 Eighteen operands of 15 (sum 270) -> out_sum=14, out_count=18; with ACC_OVF_EN, out_ovf=1.
REQ-038 Sixteen operands of 15 (sum 240) with ACC_OVF_EN -> out_sum=240, out_ovf=0.
REQ-039 rst pulsed after 2 of 4 operands, then group 6,6 -> out_sum=12, out_count=2.

Source files
------------

// File: rtl/serial_csa_accumulator.sv
// Serial carry-save accumulator: sums operand groups without carry chains in the loop.
// Optional sticky overflow flag (out_ovf) is built when ACC_OVF_EN is defined.
module serial_csa_accumulator #(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_sum,
  output logic [M-1:0] out_count
`ifdef ACC_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    OUT
  } state_e;

  localparam logic [M-1:0] ONE = 1;

  state_e       state_q, state_d;
  logic [M-1:0] s_q, s_d;
  logic [M-1:0] c_q, c_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic [M-1:0] res_q, res_d;
  logic [M-1:0] rcnt_q, rcnt_d;
  logic [M-1:0] x;
  logic [M-1:0] maj;

  assign x   = {{(M-N){1'b0}}, in_data};
  assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

`ifdef ACC_OVF_EN
  logic       ovf_q, ovf_d;
  logic [M:0] full;

  assign full    = {1'b0, s_q} + {1'b0, c_q};
  assign out_ovf = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    rcnt_d    = rcnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef ACC_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_d   = s_q ^ c_q ^ x;
          c_d   = maj << 1;
          cnt_d = cnt_q + ONE;
`ifdef ACC_OVF_EN
          // carry bit lost off the top is 2^M of true sum
          ovf_d = ovf_q | maj[M-1];
`endif
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
`ifdef ACC_OVF_EN
        res_d = full[M-1:0];
        ovf_d = ovf_q | full[M];
`else
        res_d = s_q + c_q;
`endif
        rcnt_d  = cnt_q;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
`ifdef ACC_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rcnt_q  <= '0;
`ifdef ACC_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
`ifdef ACC_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_sum   = res_q;
  assign out_count = rcnt_q;

endmodule

// File: tb/tb_serial_csa_accumulator.sv
// Bench for serial_csa_accumulator: directed groups plus random groups
// checked against a plain-arithmetic group-sum model.
module tb_serial_csa_accumulator;
  localparam int N = 4;
  localparam int M = 8;
  localparam int MOD = 1 << M;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_sum;
  logic [M-1:0] out_count;
`ifdef ACC_OVF_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int failures = 0;
  int grp[$];

  serial_csa_accumulator #(.N(N), .M(M)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_count(out_count)
`ifdef ACC_OVF_EN
    ,
    .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input bit mark_last);
    for (int i = 0; i < grp.size(); i++) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = grp[i][N-1:0];
      in_last  = mark_last && (i == grp.size() - 1);
      check("in_ready_beat", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_group(input int hold);
    int sum = 0;
    int ecnt;
    int esum;
    foreach (grp[i]) sum += grp[i];
    esum = sum % MOD;
    ecnt = grp.size() % MOD;
    send_beats(1'b1);
    out_ready = (hold == 0);
    check("resolve_valid", {31'd0, out_valid}, 32'd0);
    check("resolve_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_sum", 32'(out_sum), 32'(esum));
    check("out_count", 32'(out_count), 32'(ecnt));
`ifdef ACC_OVF_EN
    check("out_ovf", {31'd0, out_ovf}, (sum >= MOD) ? 32'd1 : 32'd0);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom);
      in_last  = 1'($urandom);
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", 32'(out_sum), 32'(esum));
      check("hold_count", 32'(out_count), 32'(ecnt));
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
`ifdef ACC_OVF_EN
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    grp = '{3, 5, 7, 9};
    run_group(0);
    grp = '{15};
    run_group(0);
    grp = '{1, 2};
    run_group(5);
    grp = '{4, 4};
    run_group(0);
    grp = {};
    repeat (18) grp.push_back(15);
    run_group(1);
    grp = {};
    repeat (16) grp.push_back(15);
    run_group(0);

    grp = '{2, 3};
    send_beats(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();
    grp = '{6, 6};
    run_group(0);

    grp = '{9, 9};
    send_beats(1'b1);
    out_ready = 1'b0;
    tick();
    check("outrst_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("outrst_valid", {31'd0, out_valid}, 32'd0);
    check("outrst_sum", 32'(out_sum), 32'd0);
    check("outrst_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    tick();
    grp = '{1};
    run_group(0);

    for (int g = 0; g < 8; g++) begin
      int len = $urandom_range(1, 24);
      grp = {};
      for (int k = 0; k < len; k++) grp.push_back($urandom_range(0, 15));
      run_group($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
